// File: rtl/fp_pkg.sv
// Shared definitions for the FP result packing stage.
// - rm_e   : RISC-V rounding-mode encodings (5..7 are treated as RNE by users).
// - err_e  : priority code reported alongside each packed result.
// - FLAG_* : bit positions inside the 5-bit {NV,DZ,OF,UF,NX} flag vector.
// - fp_canon_nan / fp_inf / fp_max_finite build special encodings for any
//   EXP_W/MAN_W pair into a wide word; callers keep the low 1+EXP_W+MAN_W bits.
package fp_pkg;

  typedef enum logic [2:0] {
    RM_RNE = 3'd0,
    RM_RTZ = 3'd1,
    RM_RDN = 3'd2,
    RM_RUP = 3'd3,
    RM_RMM = 3'd4
  } rm_e;

  typedef enum logic [2:0] {
    ERR_NONE      = 3'd0,
    ERR_INVALID   = 3'd1,
    ERR_DIVZERO   = 3'd2,
    ERR_OVERFLOW  = 3'd3,
    ERR_UNDERFLOW = 3'd4,
    ERR_INEXACT   = 3'd5
  } err_e;

  localparam int unsigned FLAG_NV = 4;
  localparam int unsigned FLAG_DZ = 3;
  localparam int unsigned FLAG_OF = 2;
  localparam int unsigned FLAG_UF = 1;
  localparam int unsigned FLAG_NX = 0;

  localparam int unsigned FP_MAX_W = 128;
  typedef logic [FP_MAX_W-1:0] fp_word_t;

  function automatic fp_word_t fp_exp_ones(int unsigned exp_w);
    fp_word_t one;
    one = fp_word_t'(1);
    return (one << exp_w) - one;
  endfunction

  function automatic fp_word_t fp_canon_nan(int unsigned exp_w, int unsigned man_w);
    fp_word_t one;
    one = fp_word_t'(1);
    return (fp_exp_ones(exp_w) << man_w) | (one << (man_w - 1));
  endfunction

  function automatic fp_word_t fp_inf(logic sign, int unsigned exp_w, int unsigned man_w);
    return (fp_word_t'(sign) << (exp_w + man_w)) | (fp_exp_ones(exp_w) << man_w);
  endfunction

  function automatic fp_word_t fp_max_finite(logic sign, int unsigned exp_w, int unsigned man_w);
    fp_word_t one;
    one = fp_word_t'(1);
    return (fp_word_t'(sign) << (exp_w + man_w))
         | ((fp_exp_ones(exp_w) - one) << man_w)
         | ((one << man_w) - one);
  endfunction

endpackage

// File: rtl/fp_round.sv
// Combinational rounder for the FP result stage.
// Inputs : sign_i, exp_i (biased), sig_untrunc_i {hidden, fraction, GRS}, rm_i.
// Outputs: rounded_o {carry, exp, frac} = {exp_i, fraction} + inc_o,
//          inc_o (round-up decision), nx_o (any discarded bit set).
module fp_round
  import fp_pkg::*;
#(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23,
  parameter int unsigned GRS_W = 3
) (
  input  logic                   sign_i,
  input  logic [EXP_W-1:0]       exp_i,
  input  logic [MAN_W+GRS_W:0]   sig_untrunc_i,
  input  logic [2:0]             rm_i,
  output logic [EXP_W+MAN_W:0]   rounded_o,
  output logic                   inc_o,
  output logic                   nx_o
);

  logic lsb;
  logic guard;
  logic sticky;
  logic unused_hidden;

  // The hidden bit is implied by the exponent and never enters the sum.
  assign unused_hidden = sig_untrunc_i[MAN_W+GRS_W];

  always_comb begin
    lsb    = sig_untrunc_i[GRS_W];
    guard  = sig_untrunc_i[GRS_W-1];
    sticky = |sig_untrunc_i[GRS_W-2:0];
    nx_o   = guard | sticky;
    case (rm_i)
      RM_RTZ:  inc_o = 1'b0;
      RM_RDN:  inc_o = sign_i & nx_o;
      RM_RUP:  inc_o = ~sign_i & nx_o;
      RM_RMM:  inc_o = guard;
      default: inc_o = guard & (sticky | lsb);
    endcase
    // Adding to the packed {exp, frac} lets a fraction carry bump the
    // exponent, which also turns a rounded-up denormal into a normal.
    rounded_o = {1'b0, exp_i, sig_untrunc_i[MAN_W+GRS_W-1:GRS_W]}
              + {{(EXP_W+MAN_W){1'b0}}, inc_o};
  end

endmodule

// File: rtl/fp_result_pack.sv
// Final FP datapath stage: rounds, classifies exceptions, packs the IEEE-754
// result into a registered valid/ready output and keeps sticky fflags.
// Ports: clk, rst_n (async, active low); in_valid/in_ready input handshake;
//        sign_i, exp_i, sig_untrunc_i, carry_i, nan_i, dz_i, rm_i operands;
//        out_valid/out_ready output handshake; fp_out packed result;
//        error_o priority code; flags_o per-result {NV,DZ,OF,UF,NX};
//        fflags_clr_i clears, fflags_o reports accumulated flags.
module fp_result_pack
  import fp_pkg::*;
#(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23,
  parameter int unsigned GRS_W = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     sign_i,
  input  logic [EXP_W-1:0]         exp_i,
  input  logic [MAN_W+GRS_W:0]     sig_untrunc_i,
  input  logic                     carry_i,
  input  logic                     nan_i,
  input  logic                     dz_i,
  input  logic [2:0]               rm_i,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [EXP_W+MAN_W:0]     fp_out,
  output logic [2:0]               error_o,
  output logic [4:0]               flags_o,
  input  logic                     fflags_clr_i,
  output logic [4:0]               fflags_o
);

  localparam int unsigned FP_W = 1 + EXP_W + MAN_W;

  logic [EXP_W+MAN_W:0] rounded;
  logic                 inc;
  logic                 nx;
  logic                 unused_inc;

  logic [EXP_W-1:0]     rexp;
  logic [MAN_W-1:0]     rfrac;
  logic                 to_inf;
  fp_word_t             special;
  logic [FP_W-1:0]      res_fp;
  logic [4:0]           res_flags;
  err_e                 res_err;

  logic                 accept;
  logic                 xfer;

  logic                 out_valid_d, out_valid_q;
  logic [FP_W-1:0]      fp_out_d, fp_out_q;
  logic [2:0]           error_d, error_q;
  logic [4:0]           flags_d, flags_q;
  logic [4:0]           fflags_d, fflags_q;

  fp_round #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W),
    .GRS_W (GRS_W)
  ) u_round (
    .sign_i        (sign_i),
    .exp_i         (exp_i),
    .sig_untrunc_i (sig_untrunc_i),
    .rm_i          (rm_i),
    .rounded_o     (rounded),
    .inc_o         (inc),
    .nx_o          (nx)
  );

  assign unused_inc = inc;

  // Exception priority: NaN, divide-by-zero, overflow, underflow, normal.
  always_comb begin
    rexp      = rounded[EXP_W+MAN_W-1:MAN_W];
    rfrac     = rounded[MAN_W-1:0];
    to_inf    = 1'b1;
    special   = '0;
    res_fp    = '0;
    res_flags = '0;
    res_err   = ERR_NONE;
    if (nan_i) begin
      special            = fp_canon_nan(EXP_W, MAN_W);
      res_fp             = special[FP_W-1:0];
      res_flags[FLAG_NV] = 1'b1;
      res_err            = ERR_INVALID;
    end else if (dz_i) begin
      special            = fp_inf(sign_i, EXP_W, MAN_W);
      res_fp             = special[FP_W-1:0];
      res_flags[FLAG_DZ] = 1'b1;
      res_err            = ERR_DIVZERO;
    end else if (carry_i || (&exp_i) || (&rexp) || rounded[EXP_W+MAN_W]) begin
      case (rm_i)
        RM_RTZ:  to_inf = 1'b0;
        RM_RDN:  to_inf = sign_i;
        RM_RUP:  to_inf = ~sign_i;
        default: to_inf = 1'b1;
      endcase
      special = to_inf ? fp_inf(sign_i, EXP_W, MAN_W)
                       : fp_max_finite(sign_i, EXP_W, MAN_W);
      res_fp             = special[FP_W-1:0];
      res_flags[FLAG_OF] = 1'b1;
      res_flags[FLAG_NX] = 1'b1;
      res_err            = ERR_OVERFLOW;
    end else if ((rexp == '0) && (rfrac != '0)) begin
      res_fp             = {sign_i, rexp, rfrac};
      res_flags[FLAG_UF] = 1'b1;
      res_flags[FLAG_NX] = nx;
      res_err            = ERR_UNDERFLOW;
    end else begin
      res_fp             = {sign_i, rexp, rfrac};
      res_flags[FLAG_NX] = nx;
      res_err            = nx ? ERR_INEXACT : ERR_NONE;
    end
  end

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign xfer     = out_valid_q && out_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    fp_out_d    = fp_out_q;
    error_d     = error_q;
    flags_d     = flags_q;
    if (accept) begin
      out_valid_d = 1'b1;
      fp_out_d    = res_fp;
      error_d     = res_err;
      flags_d     = res_flags;
    end else if (xfer) begin
      out_valid_d = 1'b0;
    end
    // Clearing first then OR-ing keeps a coincident transfer's flags.
    fflags_d = (fflags_clr_i ? 5'b0 : fflags_q) | (xfer ? flags_q : 5'b0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      fp_out_q    <= '0;
      error_q     <= '0;
      flags_q     <= '0;
      fflags_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      fp_out_q    <= fp_out_d;
      error_q     <= error_d;
      flags_q     <= flags_d;
      fflags_q    <= fflags_d;
    end
  end

  assign out_valid = out_valid_q;
  assign fp_out    = fp_out_q;
  assign error_o   = error_q;
  assign flags_o   = flags_q;
  assign fflags_o  = fflags_q;

endmodule

// File: tb/tb_fp_result_pack.sv
// Bench for fp_result_pack (single precision, GRS_W=3): directed literal
// cases, backpressure/sticky/reset sequence, then randomized traffic checked
// every cycle against a behavioural model and an in-order expectation queue.
module tb_fp_result_pack;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        sign_i;
  logic [7:0]  exp_i;
  logic [26:0] sig_untrunc_i;
  logic        carry_i;
  logic        nan_i;
  logic        dz_i;
  logic [2:0]  rm_i;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] fp_out;
  logic [2:0]  error_o;
  logic [4:0]  flags_o;
  logic        fflags_clr_i;
  logic [4:0]  fflags_o;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] fp;
    logic [4:0]  fl;
    logic [2:0]  er;
  } exp_t;

  exp_t       q[$];
  logic [4:0] fm = 5'b0;

  always #5 clk = ~clk;

  fp_result_pack #(.EXP_W(8), .MAN_W(23), .GRS_W(3)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .sign_i        (sign_i),
    .exp_i         (exp_i),
    .sig_untrunc_i (sig_untrunc_i),
    .carry_i       (carry_i),
    .nan_i         (nan_i),
    .dz_i          (dz_i),
    .rm_i          (rm_i),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .fp_out        (fp_out),
    .error_o       (error_o),
    .flags_o       (flags_o),
    .fflags_clr_i  (fflags_clr_i),
    .fflags_o      (fflags_o)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, required %h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Rounding expressed as a comparison of the discarded remainder (GRS/8)
  // against one half, then ordinary integer addition on the magnitude.
  function automatic exp_t model(input bit s, input logic [7:0] e, input logic [26:0] sig,
                                 input bit c, input bit n, input bit d, input logic [2:0] rm);
    exp_t        r;
    logic [26:0] sv;
    int unsigned frac, rem, mag, re, rf;
    bit          up, inexact, to_inf;
    sv      = sig;
    frac    = 32'(sv[25:3]);
    rem     = 32'(sv[2:0]);
    inexact = (rem != 0);
    case (rm)
      3'd1:    up = 1'b0;
      3'd2:    up = s && inexact;
      3'd3:    up = !s && inexact;
      3'd4:    up = (rem >= 4);
      default: up = (rem > 4) || (rem == 4 && (frac % 2) == 1);
    endcase
    mag = (32'(e) * 32'd8388608) + frac + (up ? 32'd1 : 32'd0);
    re  = mag / 32'd8388608;
    rf  = mag % 32'd8388608;
    if (n) begin
      r.fp = 32'h7FC00000; r.fl = 5'b10000; r.er = 3'd1;
    end else if (d) begin
      r.fp = {s, 31'h7F800000}; r.fl = 5'b01000; r.er = 3'd2;
    end else if (c || e == 8'hFF || re >= 255) begin
      case (rm)
        3'd1:    to_inf = 1'b0;
        3'd2:    to_inf = s;
        3'd3:    to_inf = !s;
        default: to_inf = 1'b1;
      endcase
      r.fp = to_inf ? {s, 31'h7F800000} : {s, 31'h7F7FFFFF};
      r.fl = 5'b00101; r.er = 3'd3;
    end else if (re == 0 && rf != 0) begin
      r.fp = {s, 8'h00, rf[22:0]}; r.fl = {3'b000, 1'b1, inexact}; r.er = 3'd4;
    end else begin
      r.fp = {s, re[7:0], rf[22:0]}; r.fl = {4'b0000, inexact}; r.er = inexact ? 3'd5 : 3'd0;
    end
    return r;
  endfunction

  // Cycle monitor: outputs must track the expectation queue; accepted inputs
  // are enqueued, transfers dequeue and fold flags into the sticky model.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      fm = 5'b0;
    end else begin
      exp_t h;
      bit   xfer;
      chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
      chk("in_ready", 64'(in_ready), 64'((q.size() == 0) || out_ready));
      chk("fflags", 64'(fflags_o), 64'(fm));
      xfer = 1'b0;
      if (q.size() != 0) begin
        h = q[0];
        chk("fp_out", 64'(fp_out), 64'(h.fp));
        chk("flags_o", 64'(flags_o), 64'(h.fl));
        chk("error_o", 64'(error_o), 64'(h.er));
        if (out_ready) begin
          xfer = 1'b1;
          void'(q.pop_front());
        end
      end
      fm = (fflags_clr_i ? 5'b0 : fm) | (xfer ? h.fl : 5'b0);
      if (in_valid && ((q.size() == 0 && !xfer) || out_ready || xfer))
        q.push_back(model(sign_i, exp_i, sig_untrunc_i, carry_i, nan_i, dz_i, rm_i));
    end
  end

  task automatic drive(input bit s, input logic [7:0] e, input logic [26:0] sig,
                       input bit c, input bit n, input bit d, input logic [2:0] rm);
    sign_i = s; exp_i = e; sig_untrunc_i = sig; carry_i = c; nan_i = n; dz_i = d; rm_i = rm;
  endtask

  task automatic directed(input string nm, input bit s, input logic [7:0] e, input logic [26:0] sig,
                          input bit c, input bit n, input bit d, input logic [2:0] rm,
                          input logic [31:0] efp, input logic [4:0] efl, input logic [2:0] eer);
    drive(s, e, sig, c, n, d, rm);
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk({nm, ".valid"}, 64'(out_valid), 64'(1));
    chk({nm, ".fp"}, 64'(fp_out), 64'(efp));
    chk({nm, ".flags"}, 64'(flags_o), 64'(efl));
    chk({nm, ".err"}, 64'(error_o), 64'(eer));
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; fflags_clr_i = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; fflags_clr_i = 1'b0;
    drive(0, 8'h00, 27'h0, 0, 0, 0, 3'd0);
    #1;
    chk("rst.valid", 64'(out_valid), 64'(0));
    chk("rst.fp", 64'(fp_out), 64'(0));
    chk("rst.err", 64'(error_o), 64'(0));
    chk("rst.flags", 64'(flags_o), 64'(0));
    chk("rst.fflags", 64'(fflags_o), 64'(0));
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    directed("rne_tie", 0, 8'h7F, 27'h400000C, 0, 0, 0, 3'd0, 32'h3F800002, 5'b00001, 3'd5);
    directed("rne_carry", 0, 8'h7F, 27'h7FFFFFC, 0, 0, 0, 3'd0, 32'h40000000, 5'b00001, 3'd5);
    directed("rtz_carry", 0, 8'h7F, 27'h7FFFFFC, 0, 0, 0, 3'd1, 32'h3FFFFFFF, 5'b00001, 3'd5);
    directed("ovf_rtz", 0, 8'hFF, 27'h4000000, 0, 0, 0, 3'd1, 32'h7F7FFFFF, 5'b00101, 3'd3);
    directed("ovf_rne", 0, 8'hFF, 27'h4000000, 0, 0, 0, 3'd0, 32'h7F800000, 5'b00101, 3'd3);
    directed("ovf_rdn_neg", 1, 8'hFF, 27'h4000000, 0, 0, 0, 3'd2, 32'hFF800000, 5'b00101, 3'd3);
    directed("nan_dz", 1, 8'h10, 27'h4000000, 0, 1, 1, 3'd0, 32'h7FC00000, 5'b10000, 3'd1);
    directed("dz", 1, 8'h10, 27'h4000000, 0, 0, 1, 3'd0, 32'hFF800000, 5'b01000, 3'd2);
    directed("underflow", 0, 8'h00, 27'h0000008, 0, 0, 0, 3'd0, 32'h00000001, 5'b00010, 3'd4);
    directed("zero", 0, 8'h00, 27'h0000000, 0, 0, 0, 3'd0, 32'h00000000, 5'b00000, 3'd0);
    directed("rm7_as_rne", 0, 8'h7F, 27'h4000004, 0, 0, 0, 3'd7, 32'h3F800000, 5'b00001, 3'd5);
    directed("rmm_tie", 0, 8'h7F, 27'h4000004, 0, 0, 0, 3'd4, 32'h3F800001, 5'b00001, 3'd5);
    directed("carry_in", 0, 8'h80, 27'h4000000, 1, 0, 0, 3'd3, 32'h7F800000, 5'b00101, 3'd3);

    // Backpressure with sticky-flag accounting from a clean state.
    do_reset();
    drive(0, 8'h00, 27'h0000008, 0, 0, 0, 3'd0);
    in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    drive(0, 8'h7F, 27'h400000C, 0, 0, 0, 3'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold.in_ready", 64'(in_ready), 64'(0));
      chk("hold.fp", 64'(fp_out), 64'(32'h00000001));
      chk("hold.flags", 64'(flags_o), 64'(5'b00010));
      chk("hold.fflags", 64'(fflags_o), 64'(0));
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; fflags_clr_i = 1'b1;
    @(negedge clk);
    chk("release.fflags", 64'(fflags_o), 64'(5'b00010));
    chk("release.next_fp", 64'(fp_out), 64'(32'h3F800002));
    @(posedge clk); #1;
    fflags_clr_i = 1'b0;
    @(negedge clk);
    chk("clr_xfer.fflags", 64'(fflags_o), 64'(5'b00001));
    chk("clr_xfer.valid", 64'(out_valid), 64'(0));
    @(negedge clk);
    chk("clr_xfer.stable", 64'(fflags_o), 64'(5'b00001));

    // Asynchronous reset while a result is held.
    @(posedge clk); #1;
    drive(0, 8'hFF, 27'h4000000, 0, 0, 0, 3'd0);
    in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("prereset.valid", 64'(out_valid), 64'(1));
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst.valid", 64'(out_valid), 64'(0));
    chk("async_rst.fflags", 64'(fflags_o), 64'(0));
    chk("async_rst.fp", 64'(fp_out), 64'(0));
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Randomized traffic.
    for (int cyc = 0; cyc < 4000; cyc++) begin
      logic [7:0]  e;
      logic [26:0] sig;
      int unsigned pick;
      pick = $urandom_range(0, 7);
      case (pick)
        0:       e = 8'h00;
        1:       e = 8'h01;
        2:       e = 8'hFE;
        3:       e = 8'hFF;
        default: e = 8'($urandom());
      endcase
      sig = 27'($urandom());
      sig[26] = (e != 8'h00);
      if ($urandom_range(0, 3) == 0) sig[25:3] = '1;
      drive(1'($urandom()), e, sig, ($urandom_range(0, 31) == 0),
            ($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0), 3'($urandom()));
      in_valid     = ($urandom_range(0, 9) < 7);
      out_ready    = ($urandom_range(0, 3) != 0);
      fflags_clr_i = ($urandom_range(0, 19) == 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1; fflags_clr_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
